// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - 640x480 VGA timing receiver: pixel coordinate recovery, geometry measurement, lock and error detection
//
// Samples pixel_clk/hs/vs/blank from the timing generator in the Clk domain.
// Recovers active pixel coordinates once locked to the expected geometry.
//
// Optional feature macro: VGA_RX_STATS_EN
//   defined   : line_len, hs_width and frame_lines are captured and reported
//   undefined : those three outputs are tied to 0
//
// Ports:
//   Clk          system clock, all logic on posedge
//   Reset        asynchronous, active-high
//   pixel_clk    pixel clock derived from Clk; its rising edge defines a pixel
//   hs, vs       active-low syncs
//   blank        high during active pixels
//   rx_valid     one-Clk strobe per active pixel while locked
//   rx_x, rx_y   coordinates of the strobed pixel (held otherwise)
//   frame_start  one-Clk pulse per vs falling edge
//   locked       high while the timing matches the expected geometry
//   err          sticky mismatch-after-lock flag, cleared only by Reset
//   line_len     last measured line length in pixels
//   hs_width     last measured hs low width in pixels
//   frame_lines  last measured lines per frame
module vga_sync_receiver #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pixel_clk,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank,
    output logic       rx_valid,
    output logic [9:0] rx_x,
    output logic [9:0] rx_y,
    output logic       frame_start,
    output logic       locked,
    output logic       err,
    output logic [9:0] line_len,
    output logic [9:0] hs_width,
    output logic [9:0] frame_lines
);

    localparam logic [9:0]  CNT_MAX    = 10'd1023;
    localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_W   = 11'(H_SYNC);
    localparam logic [9:0]  H_ACTIVE_W = 10'(H_ACTIVE);
    localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
    localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] c);
        return (c == CNT_MAX) ? c : c + 10'd1;
    endfunction

    state_t     state;
    logic       frame_bad;
    logic       pclk_q;
    logic       hs_q;
    logic       vs_q;
    logic [9:0] h_cnt;
    logic [9:0] hsw_cnt;
    logic [9:0] x_cnt;
    logic [9:0] v_cnt;
    logic [9:0] y_cnt;

    logic        pe;
    logic        hs_fall;
    logic        vs_fall;
    logic        line_act;
    logic        line_bad;
    logic        sat_bad;
    logic        mismatch;
    logic [10:0] y_close;
    logic        frame_good;

    assign pe      = pixel_clk & ~pclk_q;
    // hs_q/vs_q reset low, so the low levels seen right after Reset never look like edges
    assign hs_fall = pe & hs_q & ~hs;
    assign vs_fall = pe & vs_q & ~vs;

    // The closing pe is part of the measured line (+1), and it is always an hs-low pixel
    assign line_act = (x_cnt != 10'd0);
    assign line_bad = hs_fall & ((({1'b0, h_cnt}   + 11'd1) != H_TOTAL_W) |
                                 (({1'b0, hsw_cnt} + 11'd1) != H_SYNC_W)  |
                                 (line_act & (x_cnt != H_ACTIVE_W)));
    // A counter stuck at its ceiling means the geometry is already wrong
    assign sat_bad  = pe & ((h_cnt == CNT_MAX) | (hsw_cnt == CNT_MAX) | (x_cnt == CNT_MAX) |
                            (v_cnt == CNT_MAX) | (y_cnt == CNT_MAX));
    assign mismatch = line_bad | sat_bad;

    // Line close is folded in before the frame check when both edges land on one pe
    assign y_close    = {1'b0, y_cnt} + {10'd0, (hs_fall & line_act)};
    assign frame_good = (({1'b0, v_cnt} + 11'd1) == V_TOTAL_W) & (y_close == V_ACTIVE_W);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            h_cnt   <= 10'd0;
            hsw_cnt <= 10'd0;
            x_cnt   <= 10'd0;
            v_cnt   <= 10'd0;
            y_cnt   <= 10'd0;
        end else begin
            pclk_q <= pixel_clk;
            if (pe) begin
                hs_q    <= hs;
                vs_q    <= vs;
                h_cnt   <= hs_fall ? 10'd0 : sat_inc(h_cnt);
                hsw_cnt <= hs_fall ? 10'd0 : (~hs ? sat_inc(hsw_cnt) : hsw_cnt);
                x_cnt   <= hs_fall ? 10'd0 : (blank ? sat_inc(x_cnt) : x_cnt);
                v_cnt   <= vs_fall ? 10'd0 : (hs_fall ? sat_inc(v_cnt) : v_cnt);
                y_cnt   <= vs_fall ? 10'd0 : ((hs_fall & line_act) ? sat_inc(y_cnt) : y_cnt);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= SEARCH;
            frame_bad   <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_fall;
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state     <= CHECK;
                        frame_bad <= 1'b0;
                    end
                end
                CHECK: begin
                    if (vs_fall) begin
                        if (!frame_bad && !mismatch && frame_good) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                        // Either way the next frame is judged from scratch
                        frame_bad <= 1'b0;
                    end else if (mismatch) begin
                        frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (mismatch || (vs_fall && !frame_good)) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_valid <= 1'b0;
            rx_x     <= 10'd0;
            rx_y     <= 10'd0;
        end else begin
            rx_valid <= pe & blank & locked;
            if (pe && blank && locked) begin
                rx_x <= x_cnt;
                rx_y <= y_cnt;
            end
        end
    end

`ifdef VGA_RX_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            line_len    <= 10'd0;
            hs_width    <= 10'd0;
            frame_lines <= 10'd0;
        end else begin
            if (hs_fall) begin
                line_len <= sat_inc(h_cnt);
                hs_width <= sat_inc(hsw_cnt);
            end
            if (vs_fall) begin
                frame_lines <= sat_inc(v_cnt);
            end
        end
    end
`else
    assign line_len    = 10'd0;
    assign hs_width    = 10'd0;
    assign frame_lines = 10'd0;
`endif

endmodule
